// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and phase-step helper for the quadrature encoder generator
// Contents: gen_state_t (FSM states), DIR_FWD/DIR_REV direction codes,
//           next_phase() one Gray step of the AB pair in a given direction.
package enc_pkg;

    typedef enum logic {
        GEN_IDLE = 1'b0,
        GEN_RUN  = 1'b1
    } gen_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // AB pair: ab[1] = A, ab[0] = B.
    // Forward walks 00->10->11->01->00 (A leads B); reverse walks the same ring backwards.
    function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic dir);
        logic [1:0] nxt;
        nxt = ab;
        if (dir == DIR_FWD) begin
            case (ab)
                2'b00:   nxt = 2'b10;
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (ab)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/quad_phase_seq.sv
// rtl/quad_phase_seq.sv - 2-bit Gray phase register driving enc_a/enc_b
// Ports: clk, rst (sync, active-high), step (advance one state this edge),
//        dir (direction of that advance), enc_a/enc_b (phase outputs, taken directly from the flops).
module quad_phase_seq
    import enc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic dir,
    output logic enc_a,
    output logic enc_b
);

    logic [1:0] phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 2'b00;
        end else if (step) begin
            phase_q <= next_phase(phase_q, dir);
        end
    end

    // The phase flops are the outputs, so A/B can never glitch.
    assign enc_a = phase_q[1];
    assign enc_b = phase_q[0];

endmodule

// File: rtl/quad_enc_gen.sv
// rtl/quad_enc_gen.sv - quadrature encoder emulator: step commands in, A/B phases out
// Ports: clk, rst (sync, active-high);
//        command: cmd_valid/cmd_ready, cmd_dir, cmd_steps, cmd_period; abort;
//        outputs: enc_a, enc_b, busy, done (1-cycle), pos_count (signed, wrapping).
module quad_enc_gen
    import enc_pkg::*;
#(
    parameter int STEP_W = 16,
    parameter int DIV_W  = 16,
    parameter int POS_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0]  cmd_period,
    input  logic              abort,
    output logic              enc_a,
    output logic              enc_b,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  pos_count
);

    gen_state_t        state_q, state_d;
    logic [DIV_W-1:0]  timer_q, timer_d;
    logic [DIV_W-1:0]  period_q, period_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic              dir_q, dir_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              done_q, done_d;
    // Set for the one cycle after a command finished by emitting its last step.
    // A command accepted in that cycle is timed from that last step, not from
    // its own accept edge, so edge spacing stays uniform across commands.
    logic              chain_q, chain_d;
    logic              step;
    logic              step_dir;
    logic [DIV_W-1:0]  p_eff;

    assign p_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        period_d     = period_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        chain_d      = 1'b0;
        step         = 1'b0;
        step_dir     = dir_q;

        case (state_q)
            GEN_IDLE: begin
                // abort is ignored here; cmd_ready is high throughout IDLE
                if (cmd_valid) begin
                    dir_d    = cmd_dir;
                    period_d = p_eff;
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else if (chain_q && (p_eff == DIV_W'(1))) begin
                        // Chained with a one-cycle period: the first step is due on this very edge.
                        step     = 1'b1;
                        step_dir = cmd_dir;
                        timer_d  = p_eff;
                        if (cmd_steps == STEP_W'(1)) begin
                            done_d  = 1'b1;
                            chain_d = 1'b1;
                        end else begin
                            state_d      = GEN_RUN;
                            steps_left_d = cmd_steps - STEP_W'(1);
                        end
                    end else begin
                        state_d      = GEN_RUN;
                        steps_left_d = cmd_steps;
                        timer_d      = chain_q ? (p_eff - DIV_W'(1)) : p_eff;
                    end
                end
            end
            GEN_RUN: begin
                if (abort) begin
                    // Abort beats a step that would fall due on the same edge.
                    state_d = GEN_IDLE;
                end else if (timer_q == DIV_W'(1)) begin
                    step         = 1'b1;
                    timer_d      = period_q;
                    steps_left_d = steps_left_q - STEP_W'(1);
                    if (steps_left_q == STEP_W'(1)) begin
                        state_d = GEN_IDLE;
                        done_d  = 1'b1;
                        chain_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            default: state_d = GEN_IDLE;
        endcase

        pos_d = pos_q;
        if (step) begin
            pos_d = (step_dir == DIR_REV) ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GEN_IDLE;
            timer_q      <= '0;
            period_q     <= '0;
            steps_left_q <= '0;
            dir_q        <= DIR_FWD;
            pos_q        <= '0;
            done_q       <= 1'b0;
            chain_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            period_q     <= period_d;
            steps_left_q <= steps_left_d;
            dir_q        <= dir_d;
            pos_q        <= pos_d;
            done_q       <= done_d;
            chain_q      <= chain_d;
        end
    end

    quad_phase_seq u_phase (
        .clk   (clk),
        .rst   (rst),
        .step  (step),
        .dir   (step_dir),
        .enc_a (enc_a),
        .enc_b (enc_b)
    );

    assign cmd_ready = (state_q == GEN_IDLE);
    assign busy      = (state_q == GEN_RUN);
    assign done      = done_q;
    assign pos_count = pos_q;

endmodule
